// File: rtl/iobuf_offset_cal_if.sv
// Handshake and per-channel bus for the input-buffer offset calibrator.
// master drives start/buf_o; slave (the calibrator) drives the rest.
interface iobuf_offset_cal_if #(
  parameter int NCH = 4
);
  logic             start;
  logic             busy;
  logic             done;
  logic [NCH-1:0]   buf_o;
  logic [4*NCH-1:0] osc;
  logic [NCH-1:0]   osc_en;
  logic [4*NCH-1:0] cal_code;
  logic [NCH-1:0]   cal_fail;

  modport master (
    output start, buf_o,
    input  busy, done, osc, osc_en, cal_code, cal_fail
  );

  modport slave (
    input  start, buf_o,
    output busy, done, osc, osc_en, cal_code, cal_fail
  );
endinterface

// File: rtl/iobuf_offset_cal.sv
// Sweeps the offset code of NCH input buffers and latches the first 0->1 step.
// Define IOBUF_CAL_MAJORITY_EN to vote over SAMPLES samples per step.
module iobuf_offset_cal #(
  parameter int NCH     = 4,
  parameter int SETTLE  = 8,
  parameter int SAMPLES = 5
) (
  input logic clk,
  input logic rst,
  iobuf_offset_cal_if.slave io
);

`ifdef IOBUF_CAL_MAJORITY_EN
  localparam int W = SAMPLES;
`else
  // single-sample window; SAMPLES has no effect here
  localparam int W = (SAMPLES > 0) ? 1 : 1;
`endif
  localparam logic [3:0] HALF = 4'(W / 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_FINISH
  } state_t;

  state_t           state, state_n;
  logic [3:0]       k;
  logic [7:0]       cnt;
  logic [4*NCH-1:0] ones;
  logic [NCH-1:0]   prev, lat, fail;
  logic [NCH-1:0]   vote, lat_n, fail_n;
  logic [4*NCH-1:0] lat_code, code_n, fin_code;
  logic [4*NCH-1:0] cal_code_q;
  logic [NCH-1:0]   cal_fail_q;
  logic             cal_valid;
  logic [3:0]       code_k;
  logic             sweeping;

  function automatic logic [3:0] step_code(input logic [3:0] s);
    if (s < 4'd7) return {1'b0, 3'(4'd7 - s)};
    else if (s == 4'd7) return 4'b0000;
    else return {1'b1, 3'(s - 4'd7)};
  endfunction

  assign code_k = step_code(k);

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (io.start) state_n = ST_APPLY;
      ST_APPLY:  state_n = ST_SETTLE;
      ST_SETTLE: if (cnt == 8'(SETTLE - 1)) state_n = ST_SAMPLE;
      ST_SAMPLE: if (cnt == 8'(W - 1)) state_n = ST_EVAL;
      ST_EVAL:   state_n = (k == 4'd14) ? ST_FINISH : ST_APPLY;
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    vote     = '0;
    lat_n    = lat;
    fail_n   = fail;
    code_n   = lat_code;
    fin_code = '0;
    for (int i = 0; i < NCH; i++) begin
      vote[i] = ones[4*i +: 4] > HALF;
      // already above threshold at the most negative code
      if (k == 4'd0) begin
        if (vote[i]) fail_n[i] = 1'b1;
      end else if (!lat[i] && !fail[i] && vote[i] && !prev[i]) begin
        lat_n[i]           = 1'b1;
        code_n[4*i +: 4]   = code_k;
      end
      if (lat_n[i]) fin_code[4*i +: 4] = code_n[4*i +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      cnt        <= '0;
      ones       <= '0;
      prev       <= '0;
      lat        <= '0;
      fail       <= '0;
      lat_code   <= '0;
      cal_code_q <= '0;
      cal_fail_q <= '0;
      cal_valid  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? 8'd0 : cnt + 8'd1;
      unique case (state)
        ST_IDLE: begin
          if (io.start) begin
            k          <= '0;
            prev       <= '0;
            lat        <= '0;
            fail       <= '0;
            cal_fail_q <= '0;
          end
        end
        ST_APPLY: ones <= '0;
        ST_SAMPLE: begin
          for (int i = 0; i < NCH; i++)
            ones[4*i +: 4] <= ones[4*i +: 4] + {3'b0, io.buf_o[i]};
        end
        ST_EVAL: begin
          prev     <= vote;
          lat      <= lat_n;
          fail     <= fail_n;
          lat_code <= code_n;
          if (k == 4'd14) begin
            cal_code_q <= fin_code;
            cal_fail_q <= ~lat_n;
            cal_valid  <= 1'b1;
          end else begin
            k <= k + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sweeping = (state == ST_APPLY) || (state == ST_SETTLE) ||
                    (state == ST_SAMPLE) || (state == ST_EVAL);

  always_comb begin
    io.busy     = (state != ST_IDLE);
    io.done     = (state == ST_FINISH);
    io.cal_code = cal_code_q;
    io.cal_fail = cal_fail_q;
    io.osc      = sweeping ? {NCH{code_k}} : cal_code_q;
    io.osc_en   = sweeping ? {NCH{1'b1}} :
                  (cal_valid ? ~cal_fail_q : '0);
  end

endmodule

// File: tb/tb_iobuf_offset_cal.sv
// Bench for iobuf_offset_cal: behavioural comparator buffers plus an
// offset-search reference model over directed and random offsets.
module tb_iobuf_offset_cal;

  localparam int NCH     = 4;
  localparam int SETTLE  = 3;
  localparam int SAMPLES = 5;
`ifdef IOBUF_CAL_MAJORITY_EN
  localparam int W = SAMPLES;
`else
  localparam int W = 1;
`endif
  localparam int P   = SETTLE + W + 2;
  localparam int LIM = 15 * P + 10;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   off[NCH];
  int   cyc_g;
  bit   noise;

  iobuf_offset_cal_if #(.NCH(NCH)) bus ();

  iobuf_offset_cal #(
    .NCH(NCH),
    .SETTLE(SETTLE),
    .SAMPLES(SAMPLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // buffer fires when its own offset plus the applied correction is positive
  always_comb begin
    logic [NCH-1:0] b;
    logic [3:0]     f;
    int             a;
    int             st;
    int             j;
    b = '0;
    for (int i = 0; i < NCH; i++) begin
      f = bus.osc[4*i +: 4];
      a = f[3] ? 5 * int'(f[2:0]) : -5 * int'(f[2:0]);
      if (!bus.osc_en[i]) a = 0;
      b[i] = (off[i] + a) > 0;
    end
    st = (cyc_g > 0) ? (cyc_g - 1) / P : 0;
    j  = (cyc_g > 0) ? (cyc_g - 1) % P : 0;
    if (noise) begin
      if (st < 4) b[0] = 1'b0;
      else if (st == 4)
        b[0] = (j <= SETTLE) || (j == SETTLE + 1) || (j == SETTLE + 3);
      else b[0] = 1'b1;
    end
    bus.buf_o = b;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] enc_off(input int c);
    if (c > 0) return {1'b1, 3'(c / 5)};
    else return {1'b0, 3'((-c) / 5)};
  endfunction

  // first correction that makes the buffer fire; none or the very first -> fail
  function automatic logic [4:0] model(input int o);
    for (int s = 0; s < 15; s++) begin
      if (o + (s - 7) * 5 > 0) begin
        if (s == 0) return 5'b10000;
        return {1'b0, enc_off((s - 7) * 5)};
      end
    end
    return 5'b10000;
  endfunction

  task automatic expect_vals(output logic [15:0] ec, output logic [3:0] ef);
    logic [4:0] m;
    ec = '0;
    ef = '0;
    for (int i = 0; i < NCH; i++) begin
      m             = model(off[i]);
      ec[4*i +: 4]  = m[3:0];
      ef[i]         = m[4];
    end
  endtask

  task automatic sweep(input bit repulse, input bit chk_osc);
    int          cyc;
    logic [15:0] ec;
    logic [3:0]  ef;
    logic [3:0]  een;
    logic [15:0] eosc;
    expect_vals(ec, ef);
    een = ~ef;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc   = 1;
    cyc_g = 1;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    while (bus.done !== 1'b1 && cyc < LIM) begin
      if (chk_osc && (cyc - 1) % P == 0) begin
        eosc = {4{enc_off(((cyc - 1) / P - 7) * 5)}};
        chk("osc_sweep", 32'(bus.osc), 32'(eosc));
        chk("osc_en_sweep", 32'(bus.osc_en), 32'hf);
      end
      bus.start = repulse && (cyc == 20);
      @(posedge clk);
      #1;
      cyc++;
      cyc_g = cyc;
    end
    bus.start = 1'b0;
    chk("latency", cyc, 15 * P + 1);
    chk("busy_in_finish", 32'(bus.busy), 32'd1);
    chk("cal_code", 32'(bus.cal_code), 32'(ec));
    chk("cal_fail", 32'(bus.cal_fail), 32'(ef));
    chk("osc_final", 32'(bus.osc), 32'(ec));
    chk("osc_en_final", 32'(bus.osc_en), 32'(een));
    @(posedge clk);
    #1;
    cyc_g = 0;
    chk("done_single", 32'(bus.done), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("osc_en_hold", 32'(bus.osc_en), 32'(een));
    chk("osc_hold", 32'(bus.osc), 32'(ec));
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(bus.busy), 32'd0);
    chk({pfx, "_done"}, 32'(bus.done), 32'd0);
    chk({pfx, "_osc"}, 32'(bus.osc), 32'd0);
    chk({pfx, "_osc_en"}, 32'(bus.osc_en), 32'd0);
    chk({pfx, "_cal_code"}, 32'(bus.cal_code), 32'd0);
    chk({pfx, "_cal_fail"}, 32'(bus.cal_fail), 32'd0);
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    bus.start = 1'b0;
    off       = '{0, 0, 0, 0};
    noise     = 1'b0;
    cyc_g     = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    off = '{12, -12, 40, -40};
    sweep(1'b0, 1'b1);
    chk("mixed_code", 32'(bus.cal_code), 32'h00b2);
    chk("mixed_fail", 32'(bus.cal_fail), 32'hc);
    chk("mixed_en", 32'(bus.osc_en), 32'h3);

    off = '{10, 0, 35, -35};
    sweep(1'b1, 1'b0);
    chk("plus10_code", 32'(bus.cal_code[3:0]), 32'h1);

    off = '{12, -12, 40, -40};
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 6 * P + 2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    sweep(1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NCH; i++)
        off[i] = int'($urandom_range(90, 0)) - 45;
      sweep(1'b0, 1'b0);
    end

`ifdef IOBUF_CAL_MAJORITY_EN
    off   = '{12, -12, 10, 0};
    noise = 1'b1;
    sweep(1'b0, 1'b0);
    noise = 1'b0;
    chk("noise_code", 32'(bus.cal_code[3:0]), 32'h2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
